vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Generates 640x480@60 Hz VGA timing from the 50 MHz system clock and drives the VGA connector. It produces the pixel coordinates X_VGA/Y_VGA that the sprite buffer stages consume, samples their 1-bit R/G/B results, and registers the colour into blanking-aware 8-bit DAC outputs aligned with HSYNC/VSYNC. It also provides a pixel-enable strobe and an end-of-frame pulse for game logic.

## Interface
- CLK_DIV, 2: system clocks per pixel (>=2).
- H_VISIBLE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, pixels.
- H_SYNC, 96: horizontal sync width, pixels.
- H_BACK, 48: horizontal back porch, pixels.
- V_VISIBLE, 480: visible lines.
- V_FRONT, 10: vertical front porch, lines.
- V_SYNC, 2: vertical sync width, lines.
- V_BACK, 33: vertical back porch, lines.

- CLK  in  1  system clock, 50 MHz; single clock domain.
- reset  in  1  synchronous, active-high reset.
- R_IN  in  1  red bit from the sprite/compositor stage for the current X_VGA/Y_VGA.
- G_IN  in  1  green bit, same rules.
- B_IN  in  1  blue bit, same rules.
- X_VGA  out  10  current horizontal counter (0..H_TOTAL-1), registered.
- Y_VGA  out  10  current vertical counter (0..V_TOTAL-1), registered.
- PIXEL_EN  out  1  one-CLK strobe, once every CLK_DIV cycles.
- VGA_CLK  out  1  pixel clock to DAC.
- VGA_HS  out  1  horizontal sync, active low.
- VGA_VS  out  1  vertical sync, active low.
- VGA_BLANK_N  out  1  high during visible area.
- VGA_SYNC_N  out  1  tied 0.
- VGA_R, VGA_G, VGA_B  out  8 each  colour to DAC.
- FRAME_END  out  1  one-CLK pulse at end of frame.

## Operation
- H_TOTAL = sum of H_* params (800); V_TOTAL = sum of V_* params (525). Both must be ≤1024; counters are 10 bits and wrap only via explicit compare.
- Divider div counts 0..CLK_DIV-1. PIXEL_EN = (div == CLK_DIV-1). VGA_CLK is high when div ≥ CLK_DIV/2, giving a rising edge at div == CLK_DIV/2, mid-pixel.
- On each PIXEL_EN, the output stage registers from the current (X_VGA, Y_VGA) and the inputs. Then the counters advance:
  - X_VGA increments.
  - At H_TOTAL-1, X_VGA wraps to 0 and Y_VGA increments.
  - At V_TOTAL-1, Y_VGA wraps to 0.
- Registered outputs:
  - VGA_HS = 0 iff H_VISIBLE+H_FRONT ≤ X < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - VGA_VS = 0 iff V_VISIBLE+V_FRONT ≤ Y < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - VGA_BLANK_N = (X < H_VISIBLE) && (Y < V_VISIBLE).
  - VGA_R = {8{R_IN & visible}}; G and B likewise. Colour is forced to 0 outside the visible area regardless of the inputs.
- FRAME_END = PIXEL_EN && X == H_TOTAL-1 && Y == V_TOTAL-1. It pulses for one CLK, in the same cycle the counters wrap to (0,0).
- Outputs hold between PIXEL_EN strobes.
- R_IN/G_IN/B_IN must be combinationally valid from X_VGA/Y_VGA within one CLK. They are sampled only on PIXEL_EN.

## Timing
- Reset values:
  - div = 0; X_VGA = 0, Y_VGA = 0; PIXEL_EN = 0, VGA_CLK = 0.
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0.
  - VGA_R/G/B = 0, FRAME_END = 0.
- Reset applied mid-frame forces all of the above on the next CLK edge. No partial line completes.
- After reset is released, the first CLK with reset low is cycle 0. PIXEL_EN is first high at cycle CLK_DIV-1.
- At that edge, the registered outputs show pixel (0,0) and X_VGA becomes 1.
- Latency is one pixel period: coordinate presented → its colour and syncs appear at the next PIXEL_EN edge. Syncs and colour are always mutually aligned.
- Line period = H_TOTAL×CLK_DIV CLKs (1600). Frame period = V_TOTAL×H_TOTAL×CLK_DIV CLKs (840 000).
- If reset and PIXEL_EN coincide, reset wins.

## Test plan
- Reset: hold reset high for 5 CLKs with R_IN=G_IN=B_IN=1.
  - Required: all outputs at their reset values.
  - Release reset: PIXEL_EN is high exactly at cycle 1, X_VGA=1 after that edge, and VGA_R=8'hFF, VGA_BLANK_N=1.
- Horizontal sync: run one line.
  - VGA_HS is low for exactly 96 consecutive pixel strobes, first asserting on the strobe that registers X=656.
  - VGA_BLANK_N falls on the strobe registering X=640.
- Blanking: drive R_IN=1 constantly.
  - Required: VGA_R=0 for registered X in 640..799 and for registered Y in 480..524.
  - VGA_R=8'hFF everywhere else.
- Frame wrap: run a full frame.
  - FRAME_END pulses exactly once, one CLK wide, 840 000 CLKs after the previous pulse.
  - VGA_VS is low for exactly 2 lines (3200 CLKs), registering Y=490..491.
- Mid-frame reset: assert reset at X=300, Y=200 for 1 CLK.
  - Required: next edge X_VGA=0, Y_VGA=0, VGA_HS=1, VGA_BLANK_N=0.
  - Timing then restarts exactly as after power-on reset.
- Parameter override: CLK_DIV=4.
  - PIXEL_EN has period 4.
  - VGA_CLK is high for 2 CLKs per period.
  - Line period is 3200 CLKs.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-clock divider, wrapping H/V counters and a registered
// output stage that presents syncs, blanking and DAC colour one pixel behind X_VGA/Y_VGA.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       R_IN,
    input  logic       G_IN,
    input  logic       B_IN,
    output logic [9:0] X_VGA,
    output logic [9:0] Y_VGA,
    output logic       PIXEL_EN,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       FRAME_END
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             x_last;
    logic             y_last;
    logic             visible;
    logic             hs_active;
    logic             vs_active;

    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + DIV_ONE;
    end

    // Strobe and pixel clock are decoded from the next divider value so both leave flops.
    always_ff @(posedge CLK) begin
        if (reset) begin
            div      <= '0;
            PIXEL_EN <= 1'b0;
            VGA_CLK  <= 1'b0;
        end else begin
            div      <= div_next;
            PIXEL_EN <= (div_next == DIV_LAST);
            VGA_CLK  <= (div_next >= DIV_HALF);
        end
    end

    always_comb begin
        x_last    = (X_VGA == H_LAST);
        y_last    = (Y_VGA == V_LAST);
        visible   = (X_VGA < H_VIS) && (Y_VGA < V_VIS);
        hs_active = (X_VGA >= HS_START) && (X_VGA < HS_END);
        vs_active = (Y_VGA >= VS_START) && (Y_VGA < VS_END);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            X_VGA <= '0;
            Y_VGA <= '0;
        end else if (PIXEL_EN) begin
            if (x_last) begin
                X_VGA <= '0;
                Y_VGA <= y_last ? '0 : Y_VGA + 10'd1;
            end else begin
                X_VGA <= X_VGA + 10'd1;
            end
        end
    end

    // Colour and syncs are captured from the same coordinate, so they stay mutually aligned.
    always_ff @(posedge CLK) begin
        if (reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (PIXEL_EN) begin
            VGA_HS      <= ~hs_active;
            VGA_VS      <= ~vs_active;
            VGA_BLANK_N <= visible;
            VGA_R       <= {8{R_IN & visible}};
            VGA_G       <= {8{G_IN & visible}};
            VGA_B       <= {8{B_IN & visible}};
        end
    end

    assign FRAME_END  = PIXEL_EN & x_last & y_last & ~reset;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a small-geometry instance (CLK_DIV=2) for frame-level behaviour and a
// default-geometry instance with CLK_DIV=4; expectations come from pixel-index arithmetic.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    localparam int NI   = 2;
    localparam int NCYC = 10000;

    localparam int A_DIV = 2, A_HV = 20, A_HF = 3, A_HS = 5, A_HB = 4;
    localparam int A_VV = 12, A_VF = 2, A_VS = 2, A_VB = 3;
    localparam int B_DIV = 4, B_HV = 640, B_HF = 16, B_HS = 96, B_HB = 48;
    localparam int B_VV = 480, B_VF = 10, B_VS = 2, B_VB = 33;

    typedef struct {
        int div, hv, hf, hs, hb, vv, vf, vs, vb;
    } geom_t;

    typedef struct {
        int       cyc, x, y, nx, ny;
        bit       hs, vs, bl, fe;
        bit [7:0] r, g, b;
    } exp_t;

    logic       clk;
    logic       rst_v  [NI];
    logic       r_in   [NI];
    logic       g_in   [NI];
    logic       b_in   [NI];
    logic [9:0] x_o    [NI];
    logic [9:0] y_o    [NI];
    logic       pe_o   [NI];
    logic       vclk_o [NI];
    logic       hs_o   [NI];
    logic       vs_o   [NI];
    logic       bl_o   [NI];
    logic       sn_o   [NI];
    logic [7:0] r_o    [NI];
    logic [7:0] g_o    [NI];
    logic [7:0] b_o    [NI];
    logic       fe_o   [NI];

    vga_sync_gen #(
        .CLK_DIV(A_DIV), .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB)
    ) u_a (
        .CLK(clk), .reset(rst_v[0]), .R_IN(r_in[0]), .G_IN(g_in[0]), .B_IN(b_in[0]),
        .X_VGA(x_o[0]), .Y_VGA(y_o[0]), .PIXEL_EN(pe_o[0]), .VGA_CLK(vclk_o[0]),
        .VGA_HS(hs_o[0]), .VGA_VS(vs_o[0]), .VGA_BLANK_N(bl_o[0]), .VGA_SYNC_N(sn_o[0]),
        .VGA_R(r_o[0]), .VGA_G(g_o[0]), .VGA_B(b_o[0]), .FRAME_END(fe_o[0])
    );

    vga_sync_gen #(
        .CLK_DIV(B_DIV), .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
    ) u_b (
        .CLK(clk), .reset(rst_v[1]), .R_IN(r_in[1]), .G_IN(g_in[1]), .B_IN(b_in[1]),
        .X_VGA(x_o[1]), .Y_VGA(y_o[1]), .PIXEL_EN(pe_o[1]), .VGA_CLK(vclk_o[1]),
        .VGA_HS(hs_o[1]), .VGA_VS(vs_o[1]), .VGA_BLANK_N(bl_o[1]), .VGA_SYNC_N(sn_o[1]),
        .VGA_R(r_o[1]), .VGA_G(g_o[1]), .VGA_B(b_o[1]), .FRAME_END(fe_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic geom_t geom(input int i);
        geom_t gm;
        if (i == 0) gm = '{A_DIV, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB};
        else        gm = '{B_DIV, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB};
        return gm;
    endfunction

    function automatic int h_total(input geom_t gm);
        return gm.hv + gm.hf + gm.hs + gm.hb;
    endfunction

    function automatic int v_total(input geom_t gm);
        return gm.vv + gm.vf + gm.vs + gm.vb;
    endfunction

    // Reference: cycle c after reset is strobe number c/div, i.e. pixel index k in raster order.
    function automatic exp_t ref_pix(input int i, input int c, input bit r, input bit g, input bit b);
        geom_t gm = geom(i);
        int    ht = h_total(gm);
        int    vt = v_total(gm);
        int    k  = c / gm.div;
        bit    vis;
        exp_t  e;
        e.cyc = c;
        e.x   = k % ht;
        e.y   = (k / ht) % vt;
        e.nx  = (k + 1) % ht;
        e.ny  = ((k + 1) / ht) % vt;
        vis   = (e.x < gm.hv) && (e.y < gm.vv);
        e.hs  = !((e.x >= gm.hv + gm.hf) && (e.x < gm.hv + gm.hf + gm.hs));
        e.vs  = !((e.y >= gm.vv + gm.vf) && (e.y < gm.vv + gm.vf + gm.vs));
        e.bl  = vis;
        e.r   = (r && vis) ? 8'hFF : 8'h00;
        e.g   = (g && vis) ? 8'hFF : 8'h00;
        e.b   = (b && vis) ? 8'hFF : 8'h00;
        e.fe  = (e.x == ht - 1) && (e.y == vt - 1);
        return e;
    endfunction

    exp_t q0[$];
    exp_t q1[$];
    int   sc     [NI];
    int   fe_exp [NI];
    bit   done;

    // Stimulus: drives reset and random colour at negedge, pushing one expectation per strobe.
    initial begin
        bit   mid_done;
        bit   rr, gg, bb;
        exp_t e;
        geom_t gm;
        done     = 1'b0;
        mid_done = 1'b0;
        for (int i = 0; i < NI; i++) begin
            rst_v[i] = 1'b1; r_in[i] = 1'b1; g_in[i] = 1'b1; b_in[i] = 1'b1;
            sc[i] = 0; fe_exp[i] = 0;
        end
        repeat (5) @(negedge clk);
        for (int t = 0; t < NCYC; t++) begin
            for (int i = 0; i < NI; i++) begin
                gm = geom(i);
                if (i == 0 && !mid_done && t > 3000 && (sc[i] % gm.div == gm.div - 1) &&
                    ((sc[i] / gm.div) % h_total(gm) == 10) &&
                    (((sc[i] / gm.div) / h_total(gm)) % v_total(gm) == 5)) begin
                    // reset lands on a strobe edge mid-frame
                    rst_v[i] = 1'b1;
                    mid_done = 1'b1;
                    sc[i]    = 0;
                end else begin
                    rst_v[i] = 1'b0;
                    rr = (t < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    gg = (t < 20) ? 1'b1 : 1'($urandom_range(0, 1));
                    bb = (t < 20) ? 1'b1 : 1'($urandom_range(0, 1));
                    r_in[i] = rr; g_in[i] = gg; b_in[i] = bb;
                    if (sc[i] % gm.div == gm.div - 1) begin
                        e = ref_pix(i, sc[i], rr, gg, bb);
                        if (e.fe) fe_exp[i]++;
                        if (i == 0) q0.push_back(e);
                        else        q1.push_back(e);
                    end
                    sc[i]++;
                end
            end
            @(negedge clk);
        end
        done = 1'b1;
        repeat (20) @(negedge clk);
        $display("FAIL watchdog: monitor did not finish (actual running, required finished)");
        $fatal(1);
    end

    int   n_chk, n_err;
    int   mc      [NI];
    bit   ppe     [NI];
    bit   pfe     [NI];
    logic [9:0] px [NI];
    logic [9:0] py [NI];
    exp_t held    [NI];
    int   last_fe [NI];
    int   fe_seen [NI];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", nm, i, mc[i], act, req);
        end
    endtask

    task automatic mon(input int i);
        geom_t gm = geom(i);
        exp_t  e;
        bit    have;
        if (rst_v[i]) begin
            chk("reset_xy", i, 32'({x_o[i], y_o[i]}), 32'h0);
            chk("reset_ctl", i, 32'({pe_o[i], vclk_o[i], hs_o[i], vs_o[i], bl_o[i], sn_o[i], fe_o[i]}),
                32'b0011000);
            chk("reset_rgb", i, 32'({r_o[i], g_o[i], b_o[i]}), 32'h0);
            mc[i] = 0; ppe[i] = 1'b0; pfe[i] = 1'b0; last_fe[i] = -1;
            held[i] = '{0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        end else begin
            mc[i]++;
            if (ppe[i]) begin
                have = 1'b0;
                if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                chk("queue_underflow", i, 32'(have), 32'd1);
                if (have) begin
                    chk("strobe_cycle", i, 32'(mc[i] - 1), 32'(e.cyc));
                    chk("strobe_xy", i, 32'({px[i], py[i]}), 32'({10'(e.x), 10'(e.y)}));
                    chk("frame_end", i, 32'(pfe[i]), 32'(e.fe));
                    held[i] = e;
                end
                if (pfe[i]) begin
                    fe_seen[i]++;
                    if (last_fe[i] >= 0)
                        chk("frame_period", i, 32'(mc[i] - 1 - last_fe[i]),
                            32'(h_total(gm) * v_total(gm) * gm.div));
                    last_fe[i] = mc[i] - 1;
                end
            end else begin
                chk("frame_end_idle", i, 32'(pfe[i]), 32'd0);
            end
            chk("pixel_en", i, 32'(pe_o[i]), 32'(mc[i] % gm.div == gm.div - 1));
            chk("vga_clk", i, 32'(vclk_o[i]), 32'((mc[i] % gm.div) >= gm.div / 2));
            chk("xy", i, 32'({x_o[i], y_o[i]}), 32'({10'(held[i].nx), 10'(held[i].ny)}));
            chk("sync", i, 32'({hs_o[i], vs_o[i], bl_o[i], sn_o[i]}),
                32'({held[i].hs, held[i].vs, held[i].bl, 1'b0}));
            chk("rgb", i, 32'({r_o[i], g_o[i], b_o[i]}), 32'({held[i].r, held[i].g, held[i].b}));
            ppe[i] = pe_o[i]; pfe[i] = fe_o[i]; px[i] = x_o[i]; py[i] = y_o[i];
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        for (int i = 0; i < NI; i++) begin
            mc[i] = 0; ppe[i] = 1'b0; pfe[i] = 1'b0; last_fe[i] = -1; fe_seen[i] = 0;
            px[i] = '0; py[i] = '0;
        end
    end

    // Monitor samples just after each edge, decoupled from the stimulus process.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) mon(i);
        if (done) begin
            for (int i = 0; i < NI; i++) chk("frame_end_count", i, 32'(fe_seen[i]), 32'(fe_exp[i]));
            chk("frame_end_seen", 0, 32'(fe_seen[0] >= 4), 32'd1);
            chk("queue_drain", 0, 32'(q0.size() > 1), 32'd0);
            chk("queue_drain", 1, 32'(q1.size() > 1), 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
            $finish;
        end
    end

endmodule
